cnn_kernel_mac_pipe: RTL and testbench



---
 rtl/cnn_kernel_mac_pipe_pkg.sv | 32 +++
 rtl/cnn_kernel_mac_pipe_if.sv | 30 +++
 rtl/cnn_kernel_mac_pipe_requant.sv | 61 ++++++
 rtl/cnn_kernel_mac_pipe.sv | 143 ++++++++++++++
 tb/tb_cnn_kernel_mac_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_kernel_mac_pipe_pkg.sv
// Shared widths and helpers for the parametrised KX x KY kernel MAC.
// Sideband bundle carried alongside the data through the pipeline.
package cnn_kernel_mac_pipe_pkg;

   localparam int KX     = 5;
   localparam int KY     = 5;
   localparam int NK     = KX * KY;
   localparam int IBW    = 20;
   localparam int W_BW   = 7;
   localparam int B_BW   = 16;
   localparam int M_BW   = IBW + W_BW;
   localparam int ACC_BW = 40;
   localparam int OBW    = 20;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   localparam int RS_BW = M_BW + clog2(KX);

   typedef struct packed {
      logic            first;
      logic            last;
      logic            relu;
      logic [B_BW-1:0] bias;
   } side_t;

endpackage

// File: rtl/cnn_kernel_mac_pipe_if.sv
// Beat input and result output bundle of the kernel MAC.
// master drives beats, slave is the MAC itself.
interface cnn_kernel_mac_pipe_if;
   import cnn_kernel_mac_pipe_pkg::*;

   logic                 i_in_valid;
   logic                 i_first_ch;
   logic                 i_last_ch;
   logic [NK*IBW-1:0]    i_in_fmap;
   logic [NK*W_BW-1:0]   i_cnn_weight;
   logic [B_BW-1:0]      i_bias;
   logic                 i_relu_en;
   logic                 o_ot_valid;
   logic [OBW-1:0]       o_ot_acc;
   logic                 o_ot_sat;
   logic                 o_proto_err;

   modport master (
      output i_in_valid, i_first_ch, i_last_ch, i_in_fmap,
      output i_cnn_weight, i_bias, i_relu_en,
      input  o_ot_valid, o_ot_acc, o_ot_sat, o_proto_err
   );

   modport slave (
      input  i_in_valid, i_first_ch, i_last_ch, i_in_fmap,
      input  i_cnn_weight, i_bias, i_relu_en,
      output o_ot_valid, o_ot_acc, o_ot_sat, o_proto_err
   );

endinterface

// File: rtl/cnn_kernel_mac_pipe_requant.sv
// Registered round / arithmetic shift / ReLU / saturate stage.
// Shared between the conv kernel MAC and the FC stage.
module cnn_requant_sat #(
   parameter int ACC_BW = 40,
   parameter int SHIFT  = 8,
   parameter int OBW    = 20
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic signed [ACC_BW-1:0] acc,
   input  logic                     relu,
   output logic                     out_valid,
   output logic        [OBW-1:0]    res,
   output logic                     sat
);

   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_BW:0] RND =
      (SHIFT > 0) ? ((ACC_BW+1)'(1) <<< RS) : '0;
   localparam logic signed [ACC_BW:0] MAXV =
      (ACC_BW+1)'((64'sd1 <<< (OBW-1)) - 64'sd1);
   localparam logic signed [ACC_BW:0] MINV = ~MAXV;

   logic signed [ACC_BW:0] sum;
   logic signed [ACC_BW:0] r;

   // One guard bit keeps the rounding add from wrapping.
   always_comb begin
      sum = {acc[ACC_BW-1], acc} + RND;
      r   = sum >>> SHIFT;
      if (relu && r[ACC_BW]) r = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         res       <= '0;
         sat       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            unique case (1'b1)
               (r > MAXV): begin
                  res <= MAXV[OBW-1:0];
                  sat <= 1'b1;
               end
               (r < MINV): begin
                  res <= MINV[OBW-1:0];
                  sat <= 1'b1;
               end
               default: begin
                  res <= r[OBW-1:0];
                  sat <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/cnn_kernel_mac_pipe.sv
// KX x KY convolution MAC with multi-channel accumulation, bias,
// requantisation, ReLU and saturation; free-running valid pipeline.
module cnn_kernel_mac_pipe
   import cnn_kernel_mac_pipe_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   cnn_kernel_mac_pipe_if.slave  bus
);

   logic signed [IBW-1:0]    fm [NK];
   logic signed [W_BW-1:0]   wt [NK];
   side_t                    side_in;

   always_comb begin
      for (int k = 0; k < NK; k++) begin
         fm[k] = bus.i_in_fmap[k*IBW +: IBW];
         wt[k] = bus.i_cnn_weight[k*W_BW +: W_BW];
      end
      side_in = '{first: bus.i_first_ch, last: bus.i_last_ch,
                  relu: bus.i_relu_en, bias: bus.i_bias};
   end

   logic v1, v2, v3, v4;
   side_t s1, s2, s3;
   (* use_dsp = "yes" *) logic signed [M_BW-1:0] prod [NK];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0;
         s1 <= '0;
         for (int k = 0; k < NK; k++) prod[k] <= '0;
      end else begin
         v1 <= bus.i_in_valid;
         if (bus.i_in_valid) begin
            s1 <= side_in;
            for (int k = 0; k < NK; k++)
               prod[k] <= M_BW'(fm[k]) * M_BW'(wt[k]);
         end
      end
   end

   logic signed [RS_BW-1:0] row_c [KY];
   logic signed [RS_BW-1:0] rows  [KY];

   always_comb begin
      for (int y = 0; y < KY; y++) begin
         row_c[y] = '0;
         for (int x = 0; x < KX; x++)
            row_c[y] = row_c[y] + RS_BW'(prod[y*KX+x]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2 <= 1'b0;
         s2 <= '0;
         for (int y = 0; y < KY; y++) rows[y] <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            s2 <= s1;
            for (int y = 0; y < KY; y++) rows[y] <= row_c[y];
         end
      end
   end

   logic signed [ACC_BW-1:0] ksum_c, ksum;

   always_comb begin
      ksum_c = '0;
      for (int y = 0; y < KY; y++)
         ksum_c = ksum_c + ACC_BW'(rows[y]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v3   <= 1'b0;
         s3   <= '0;
         ksum <= '0;
      end else begin
         v3 <= v2;
         if (v2) begin
            s3   <= s2;
            ksum <= ksum_c;
         end
      end
   end

   logic signed [ACC_BW-1:0] acc;
   logic                     open, relu4, err;

   // A stray non-first beat accumulates but never opens the window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v4    <= 1'b0;
         acc   <= '0;
         open  <= 1'b0;
         relu4 <= 1'b0;
         err   <= 1'b0;
      end else begin
         v4 <= v3 && s3.last;
         if (v3) begin
            relu4 <= s3.relu;
            if (s3.first) begin
               acc  <= ksum + ACC_BW'($signed(s3.bias));
               open <= !s3.last;
               if (open) err <= 1'b1;
            end else begin
               acc  <= acc + ksum;
               open <= open && !s3.last;
               if (!open) err <= 1'b1;
            end
         end
      end
   end

   logic           ot_valid, ot_sat;
   logic [OBW-1:0] ot_acc;

   cnn_requant_sat #(
      .ACC_BW (ACC_BW),
      .SHIFT  (SHIFT),
      .OBW    (OBW)
   ) u_rq (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (v4),
      .acc       (acc),
      .relu      (relu4),
      .out_valid (ot_valid),
      .res       (ot_acc),
      .sat       (ot_sat)
   );

   assign bus.o_ot_valid  = ot_valid;
   assign bus.o_ot_acc    = ot_acc;
   assign bus.o_ot_sat    = ot_sat;
   assign bus.o_proto_err = err;

endmodule

// File: tb/tb_cnn_kernel_mac_pipe.sv
// Bench for cnn_kernel_mac_pipe: SHIFT=0 and SHIFT=2 instances fed
// identical beats, checked every cycle against a per-pixel model.
module tb_cnn_kernel_mac_pipe;
   import cnn_kernel_mac_pipe_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cnn_kernel_mac_pipe_if bus0 ();
   cnn_kernel_mac_pipe_if bus2 ();

   cnn_kernel_mac_pipe #(.SHIFT(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0));
   cnn_kernel_mac_pipe #(.SHIFT(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2));

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int fm [NK];
   int wt [NK];

   typedef struct {
      int     due;
      longint r0, r2;
      bit     s0, s2;
   } exp_t;

   exp_t   q [$];
   longint m_acc = 0;
   bit     m_open = 0;
   int     err_time = -1;
   longint h0 = 0, h2 = 0;
   bit     hs0 = 0, hs2 = 0;
   bit     ev;

   task automatic check(string tag, logic signed [63:0] got,
                        logic signed [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)",
                  tag, got, want, cyc);
      end
   endtask

   function automatic longint wrap_acc(input longint v);
      return (v <<< (64 - ACC_BW)) >>> (64 - ACC_BW);
   endfunction

   function automatic void rq(input longint a, input int sh,
                              input bit relu, output longint r,
                              output bit s);
      longint t;
      t = a + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
      t = t >>> sh;
      if (relu && t < 0) t = 0;
      s = 1'b0;
      if (t > 524287) begin
         t = 524287;
         s = 1'b1;
      end else if (t < -524288) begin
         t = -524288;
         s = 1'b1;
      end
      r = t;
   endfunction

   function automatic void model_clear();
      q.delete();
      m_acc = 0;
      m_open = 0;
      err_time = -1;
      h0 = 0; h2 = 0; hs0 = 0; hs2 = 0;
   endfunction

   function automatic void model_beat(input int n, input bit f,
                                      input bit l, input bit relu,
                                      input int bias);
      longint ks;
      exp_t e;
      bit perr;
      ks = 0;
      for (int k = 0; k < NK; k++) ks += longint'(fm[k]) * wt[k];
      perr = f ? m_open : !m_open;
      if (f) m_acc = wrap_acc(ks + bias);
      else   m_acc = wrap_acc(m_acc + ks);
      m_open = f ? !l : (m_open && !l);
      if (perr && err_time < 0) err_time = n + 4;
      if (l) begin
         e.due = n + 5;
         rq(m_acc, 0, relu, e.r0, e.s0);
         rq(m_acc, 2, relu, e.r2, e.s2);
         q.push_back(e);
      end
   endfunction

   task automatic beat(input bit v, input bit f, input bit l,
                       input bit relu, input int bias);
      logic [NK*IBW-1:0]  fv;
      logic [NK*W_BW-1:0] wv;
      for (int k = 0; k < NK; k++) begin
         fv[k*IBW +: IBW]   = IBW'(fm[k]);
         wv[k*W_BW +: W_BW] = W_BW'(wt[k]);
      end
      bus0.i_in_valid = v;    bus2.i_in_valid = v;
      bus0.i_first_ch = f;    bus2.i_first_ch = f;
      bus0.i_last_ch = l;     bus2.i_last_ch = l;
      bus0.i_relu_en = relu;  bus2.i_relu_en = relu;
      bus0.i_bias = B_BW'(bias);
      bus2.i_bias = B_BW'(bias);
      bus0.i_in_fmap = fv;    bus2.i_in_fmap = fv;
      bus0.i_cnn_weight = wv; bus2.i_cnn_weight = wv;
      if (v) model_beat(cyc, f, l, relu, bias);
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int f, input int w);
      for (int k = 0; k < NK; k++) begin
         fm[k] = f;
         wt[k] = w;
      end
   endtask

   task automatic fill_rand(input bit full);
      for (int k = 0; k < NK; k++) begin
         if (full) fm[k] = int'($urandom_range(0, 1048575)) - 524288;
         else      fm[k] = int'($urandom_range(0, 100)) - 50;
         wt[k] = int'($urandom_range(0, 127)) - 64;
      end
   endtask

   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) begin
         fill_rand(1'b1);
         beat(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 65535)) - 32768);
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      model_clear();
      bubble(1);
      reset_n = 1'b1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ev = (q.size() > 0 && q[0].due == cyc);
      if (ev) begin
         h0 = q[0].r0; hs0 = q[0].s0;
         h2 = q[0].r2; hs2 = q[0].s2;
         void'(q.pop_front());
      end
      check("valid0", bus0.o_ot_valid, ev);
      check("valid2", bus2.o_ot_valid, ev);
      check("acc0", $signed(bus0.o_ot_acc), h0);
      check("acc2", $signed(bus2.o_ot_acc), h2);
      check("sat0", bus0.o_ot_sat, hs0);
      check("sat2", bus2.o_ot_sat, hs2);
      check("err0", bus0.o_proto_err, err_time >= 0 && cyc >= err_time);
      check("err2", bus2.o_proto_err, err_time >= 0 && cyc >= err_time);
   end

   initial begin
      bit v, f, l;
      model_clear();
      bubble(1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      bubble(2);

      // single channel, all ones: 25
      fill(1, 1);
      beat(1, 1, 1, 0, 0);
      bubble(6);

      // three channels back-to-back: 10+150-100+25 = 85
      fill(2, 3);  beat(1, 1, 0, 0, 10);
      fill(-1, 4); beat(1, 0, 0, 0, 0);
      fill(1, 1);  beat(1, 0, 1, 0, 0);
      bubble(6);

      // same pixel with garbage bubbles in between
      fill(2, 3);  beat(1, 1, 0, 0, 10);
      bubble(2);
      fill(-1, 4); beat(1, 0, 0, 0, 0);
      bubble(2);
      fill(1, 1);  beat(1, 0, 1, 0, 0);
      bubble(6);

      // -500 with and without ReLU
      fill(-4, 5); beat(1, 1, 1, 1, 0);
      fill(-4, 5); beat(1, 1, 1, 0, 0);
      bubble(6);

      // saturation both ways
      fill(524287, 63);  beat(1, 1, 1, 0, 0);
      fill(-524288, 63); beat(1, 1, 1, 0, 0);
      bubble(6);

      // first while open restarts and flags
      fill(3, 3);  beat(1, 1, 0, 0, 100);
      fill(1, -2); beat(1, 1, 1, 0, -7);
      bubble(8);

      // reset mid-pixel drops it and clears the flag
      fill(2, 3);  beat(1, 1, 0, 0, 10);
      fill(-1, 4); beat(1, 0, 0, 0, 0);
      pulse_reset();
      bubble(8);

      for (int i = 0; i < 1500; i++) begin
         fill_rand($urandom_range(0, 7) == 0);
         v = ($urandom_range(0, 3) != 0);
         f = m_open ? ($urandom_range(0, 9) == 0)
                    : ($urandom_range(0, 9) != 0);
         l = ($urandom_range(0, 2) == 0);
         beat(v, f, l, 1'($urandom),
              int'($urandom_range(0, 65535)) - 32768);
      end
      bubble(10);
      check("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
